// File: rtl/sparce_mem_arbiter_pkg.sv
// sparceMemPkg -- shared types and helpers for the sparce memory arbiter.
//   ADDR_WIDTH / DATA_WIDTH : default address / data widths
//   BC    : bytes per memory word (width of the byte-enable bus)
//   BADDR : number of byte-offset address bits inside one word
//   mem_op_e    : access size of a request (NOP means "no access")
//   arb_state_e : arbiter FSM states
//   op_be()         : byte-enable pattern of an access size at offset 0
//   op_misaligned() : natural-alignment test for an access size and offset
package sparceMemPkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int BC         = DATA_WIDTH / 8;
  localparam int BADDR      = $clog2(BC);

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    BYTE_OP  = 3'd1,
    HALF_OP  = 3'd2,
    WORD_OP  = 3'd3,
    DWORD_OP = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic logic [BC-1:0] op_be(mem_op_e op);
    logic [BC-1:0] be;
    case (op)
      BYTE_OP:  be = BC'(8'h01);
      HALF_OP:  be = BC'(8'h03);
      WORD_OP:  be = BC'(8'h0F);
      DWORD_OP: be = BC'(8'hFF);
      default:  be = '0;
    endcase
    return be;
  endfunction

  function automatic logic op_misaligned(mem_op_e op, logic [BADDR-1:0] offset);
    logic [2:0] off3;
    logic       mis;
    off3 = 3'(offset);
    case (op)
      HALF_OP:  mis = off3[0];
      WORD_OP:  mis = (off3[1:0] != 2'b00);
      DWORD_OP: mis = (off3 != 3'b000);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/sparce_mem_arbiter_lane_align.sv
// sparce_mem_lane_align -- purely combinational byte-lane steering.
//   op_i        : access size of the latched request
//   offset_i    : byte offset inside the memory word
//   wdata_i     : LSB-justified write data
//   rdata_raw_i : raw memory word
//   be_o        : byte enables placed on the addressed lanes
//   wdata_o     : write data moved onto the addressed lanes
//   rdata_o     : read data moved down to bit 0 and masked to the access size
module sparce_mem_lane_align
  import sparceMemPkg::*;
#(
  parameter int DATA_WIDTH = sparceMemPkg::DATA_WIDTH
) (
  input  mem_op_e               op_i,
  input  logic [BADDR-1:0]      offset_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_raw_i,
  output logic [BC-1:0]         be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [BC-1:0]         size_be;
  logic [DATA_WIDTH-1:0] size_mask;
  logic [DATA_WIDTH-1:0] rdata_shift;

  always_comb begin
    size_be     = op_be(op_i);
    size_mask   = '0;
    be_o        = size_be << offset_i;
    wdata_o     = wdata_i << {offset_i, 3'b000};
    rdata_shift = rdata_raw_i >> {offset_i, 3'b000};
    // The offset-0 byte-enable pattern doubles as the size mask once each
    // enable bit is widened to a full byte.
    for (int b = 0; b < BC; b++) begin
      size_mask[8*b +: 8] = {8{size_be[b]}};
    end
    rdata_o = rdata_shift & size_mask;
  end

endmodule

// File: rtl/sparce_mem_arbiter.sv
// sparce_mem_arbiter -- two-requester round-robin arbiter in front of a
// single-outstanding word-wide memory port with byte-lane alignment.
//   req_*  : per-requester request (valid/ready), write flag, size, address, data
//   rsp_*  : one-cycle response strobe to the granted requester, data, error
//   mem_*  : memory request (valid/ready), completion strobe and raw read word
// Handshakes: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both 1; the memory request transfers on a cycle where
// mem_valid and mem_ready are both 1, and mem_valid holds with stable fields
// until then. rsp_valid and mem_rsp_valid are single-cycle strobes with no
// back-pressure.
// Optional build macro SPARCE_MEM_ARB_TIMEOUT_EN adds a watchdog over
// ISSUE/WAIT that forces an error response after TIMEOUT cycles.
module sparce_mem_arbiter
  import sparceMemPkg::*;
#(
  parameter int ADDR_WIDTH = sparceMemPkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sparceMemPkg::DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_we,
  input  mem_op_e                  req_op [2],
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [BC-1:0]            mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;   // requester granted most recently
  logic                  win_q, win_d;     // requester currently being served
  logic                  we_q, we_d;
  mem_op_e               op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  pick;
  logic [1:0]            grant;
  logic                  tmo_hit;
  logic [BC-1:0]         be_lane;
  logic [DATA_WIDTH-1:0] wdata_lane, rdata_lane;

  // On a tie the requester not granted last wins; otherwise the lone one.
  assign pick = (req_valid == 2'b11) ? ~last_q : ~req_valid[0];

  sparce_mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .op_i        (op_q),
    .offset_i    (addr_q[BADDR-1:0]),
    .wdata_i     (wdata_q),
    .rdata_raw_i (mem_rdata),
    .be_o        (be_lane),
    .wdata_o     (wdata_lane),
    .rdata_o     (rdata_lane)
  );

`ifdef SPARCE_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent in ISSUE plus WAIT; cleared everywhere else.
  always_comb begin
    cnt_d = '0;
    if (state_q == ISSUE || state_q == WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tmo_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    grant   = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant   = pick ? 2'b10 : 2'b01;
          win_d   = pick;
          last_d  = pick;
          we_d    = req_we[pick];
          op_d    = req_op[pick];
          addr_d  = req_addr[pick];
          wdata_d = req_wdata[pick];
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_op[pick] == NOP) begin
            state_d = RESP;
          end else if (op_misaligned(req_op[pick], req_addr[pick][BADDR-1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d = WAIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = we_q ? '0 : rdata_lane;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      op_q    <= NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A grant during the reset cycle would be lost, so it is suppressed.
  assign req_ready = rst ? 2'b00 : grant;

  assign mem_valid = (state_q == ISSUE);
  assign mem_we    = mem_valid & we_q;
  assign mem_addr  = mem_valid ? {addr_q[ADDR_WIDTH-1:BADDR], {BADDR{1'b0}}} : '0;
  assign mem_be    = mem_valid ? be_lane : '0;
  assign mem_wdata = mem_valid ? wdata_lane : '0;

  assign rsp_valid = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err   = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_sparce_mem_arbiter.sv
// tb_sparce_mem_arbiter -- self-checking bench for sparce_mem_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 ns later, so the
// sample shows exactly what the next rising edge acts on. A cycle-level
// reference model (phases idle / issue / wait / resp) predicts grants, memory
// requests and responses. Define SPARCE_MEM_ARB_TIMEOUT_EN to include the
// watchdog checks.
module tb_sparce_mem_arbiter;
  import sparceMemPkg::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int TMO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req_valid = '0, req_ready, req_we = '0;
  mem_op_e             req_op [2];
  logic [1:0][AW-1:0]  req_addr = '0;
  logic [1:0][DW-1:0]  req_wdata = '0;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err, mem_valid, mem_we;
  logic                mem_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [AW-1:0]       mem_addr;
  logic [BW-1:0]       mem_be;
  logic [DW-1:0]       mem_wdata, mem_rdata = '0;

  always #5 clk = ~clk;

  sparce_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  // ---------------- scoreboard ----------------
  int            n_cmp = 0, n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_err_q[$];

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // ---------------- stimulus knobs and next-cycle drive values ----------------
  bit                 auto_req = 0, contend = 0, fixed_rd_en = 0;
  int                 ready_pct = 100, dly_min = 0, dly_max = 0, spur_pct = 0, rst_pm = 0;
  logic [DW-1:0]      fixed_rd = '0;
  logic [1:0]         nxt_valid = '0, nxt_we = '0;
  mem_op_e            nxt_op [2];
  logic [1:0][AW-1:0] nxt_addr = '0;
  logic [1:0][DW-1:0] nxt_wdata = '0;
  logic               nxt_rst = 1'b1;

  // ---------------- reference model state ----------------
  int            m_phase = 0;  // 0 idle, 1 issue, 2 wait, 3 resp
  int            m_last = 1, m_cur = 0, m_delay = 0, m_spent = 0, m_size = 0, m_off = 0;
  logic          m_we;
  logic [AW-1:0] m_mem_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata;
  int            cycle = 0, acc_cycle = 0, rsp_cnt = 0, mem_vcnt = 0;
  int            grant_log[$];
  logic [DW-1:0] last_rdata, last_wdata;
  logic          last_err;
  logic [BW-1:0] last_be;
  logic [AW-1:0] last_addr;
  int            last_lat;

  function automatic int op_size(mem_op_e op);
    case (op)
      BYTE_OP:  return 1;
      HALF_OP:  return 2;
      WORD_OP:  return 4;
      DWORD_OP: return 8;
      default:  return 0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic we, input mem_op_e op,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    nxt_we[i] = we; nxt_op[i] = op; nxt_addr[i] = a; nxt_wdata[i] = d; nxt_valid[i] = 1'b1;
  endtask

  task automatic new_req(input int i);
    logic [AW-1:0] a;
    mem_op_e       op;
    op = mem_op_e'(3'($urandom_range(0, 4)));
    a  = $urandom;
    if (op_size(op) > 1 && $urandom_range(0, 1) == 1) a = a & ~AW'(op_size(op) - 1);
    set_req(i, 1'($urandom_range(0, 1)), op, a, {$urandom, $urandom});
  endtask

  task automatic accept(input int win);
    m_cur = win; m_last = win; nxt_valid[win] = 1'b0;
    grant_log.push_back(win); acc_cycle = cycle;
    m_size = op_size(req_op[win]);
    m_off  = int'(req_addr[win][2:0]);
    m_we   = req_we[win];
    if (m_size == 0) begin
      exp_q.push_back('0); exp_err_q.push_back(1'b0); m_phase = 3;
    end else if (m_off % m_size != 0) begin
      exp_q.push_back('0); exp_err_q.push_back(1'b1); m_phase = 3;
    end else begin
      m_phase    = 1; m_spent = 0;
      m_mem_addr = req_addr[win] & ~AW'(7);
      m_be       = BW'(((1 << m_size) - 1) << m_off);
      m_wdata    = req_wdata[win] << (8 * m_off);
    end
  endtask

  task automatic timeout_step();
`ifdef SPARCE_MEM_ARB_TIMEOUT_EN
    if (m_spent >= TMO) begin
      exp_q.push_back('0); exp_err_q.push_back(1'b1); m_phase = 3;
    end
`endif
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic run_cycle();
    int            win;
    logic [1:0]    exp_ready;
    logic [DW-1:0] e, mask;
    logic          ee;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!nxt_valid[i] && (contend || (auto_req && $urandom_range(0, 3) == 0))) new_req(i);
    end
    req_valid = nxt_valid; req_we = nxt_we; req_op = nxt_op;
    req_addr = nxt_addr; req_wdata = nxt_wdata;
    rst = nxt_rst | (rst_pm > 0 && $urandom_range(1, 1000) <= rst_pm);
    mem_ready     = ($urandom_range(1, 100) <= ready_pct);
    mem_rdata     = fixed_rd_en ? fixed_rd : {$urandom, $urandom};
    mem_rsp_valid = (m_phase == 2) ? (m_delay == 0) : ($urandom_range(1, 100) <= spur_pct);
    #1;
    cycle++;
    win       = (req_valid == 2'b11) ? (m_last == 1 ? 0 : 1) : (req_valid[0] ? 0 : 1);
    exp_ready = (m_phase == 0 && |req_valid && !rst) ? 2'(1 << win) : 2'b00;
    check("req_ready", DW'(req_ready), DW'(exp_ready));
    check("mem_valid", DW'(mem_valid), DW'(m_phase == 1));
    if (mem_valid) mem_vcnt++;
    if (m_phase == 1) begin
      check("mem_addr", DW'(mem_addr), DW'(m_mem_addr));
      check("mem_be", DW'(mem_be), DW'(m_be));
      check("mem_wdata", mem_wdata, m_wdata);
      check("mem_we", DW'(mem_we), DW'(m_we));
      if (mem_ready) begin
        last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
      end
    end
    check("rsp_valid", DW'(rsp_valid), (m_phase == 3) ? DW'(1 << m_cur) : '0);
    if (rsp_valid != 2'b00) rsp_cnt++;
    if (m_phase == 3) begin
      if (exp_q.size() == 0) begin
        check("rsp_queue", 1, 0);
      end else begin
        e = exp_q.pop_front(); ee = exp_err_q.pop_front();
        check("rsp_rdata", rsp_rdata, e);
        check("rsp_err", DW'(rsp_err), DW'(ee));
      end
      last_rdata = rsp_rdata; last_err = rsp_err; last_lat = cycle - acc_cycle;
    end
    if (rst) begin
      m_phase = 0; m_last = 1;
      exp_q.delete(); exp_err_q.delete();
    end else begin
      case (m_phase)
        0: if (|req_valid) accept(win);
        1: begin
          m_spent++;
          if (mem_ready) begin
            m_phase = 2; m_delay = $urandom_range(dly_min, dly_max);
          end else timeout_step();
        end
        2: begin
          m_spent++;
          if (mem_rsp_valid) begin
            mask = (m_size == 8) ? '1 : ((DW'(1) << (8 * m_size)) - 1);
            e    = m_we ? '0 : ((mem_rdata >> (8 * m_off)) & mask);
            exp_q.push_back(e); exp_err_q.push_back(1'b0); m_phase = 3;
          end else begin
            if (m_delay > 0) m_delay--;
            timeout_step();
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_phase != 0 || nxt_valid != 2'b00) && n < 200) begin
      run_cycle(); n++;
    end
    if (m_phase != 0 || nxt_valid != 2'b00) check("drain_budget", 1, 0);
  endtask

  task automatic do_reset();
    nxt_rst = 1'b1; run_n(2);
    nxt_rst = 1'b0; run_cycle();
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    int g0, r0, v0;
    req_op[0] = NOP; req_op[1] = NOP; nxt_op[0] = NOP; nxt_op[1] = NOP;

    // reset state
    do_reset();
    check("reset_outputs", DW'(|{req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid,
                                 mem_we, mem_addr, mem_be, mem_wdata}), 0);

    // word read on requester 0 with immediate memory
    ready_pct = 100; dly_min = 0; dly_max = 0; fixed_rd_en = 1;
    fixed_rd = 64'hAABBCCDD_11223344;
    set_req(0, 1'b0, WORD_OP, 32'h0000_1004, '0);
    wait_idle();
    check("rd_mem_addr", DW'(last_addr), 64'h1000);
    check("rd_mem_be", DW'(last_be), 64'hF0);
    check("rd_rdata", last_rdata, 64'hAABBCCDD);
    check("rd_latency", DW'(last_lat), 3);
    fixed_rd_en = 0;

    // byte write on requester 1
    set_req(1, 1'b1, BYTE_OP, 32'h0000_2003, 64'h5A);
    wait_idle();
    check("wr_mem_be", DW'(last_be), 64'h08);
    check("wr_mem_wdata", last_wdata, 64'h5A00_0000);
    check("wr_rsp_err", DW'(last_err), 0);
    check("wr_rsp_rdata", last_rdata, 0);

    // misaligned half and NOP never touch memory
    v0 = mem_vcnt; r0 = rsp_cnt;
    set_req(0, 1'b0, HALF_OP, 32'h0000_3001, '0);
    wait_idle();
    check("mis_rsp_err", DW'(last_err), 1);
    set_req(1, 1'b0, NOP, 32'h0000_4000, '0);
    wait_idle();
    check("nop_rsp_err", DW'(last_err), 0);
    check("nop_rsp_rdata", last_rdata, 0);
    check("err_no_mem_valid", DW'(mem_vcnt - v0), 0);
    check("err_rsp_count", DW'(rsp_cnt - r0), 2);

    // reset while waiting on memory, then a late completion
    dly_min = 100; dly_max = 100;
    set_req(0, 1'b0, DWORD_OP, 32'h0000_5000, '0);
    for (int k = 0; k < 20 && m_phase != 2; k++) run_cycle();
    check("rst_reached_wait", DW'(m_phase), 2);
    r0 = rsp_cnt;
    nxt_rst = 1'b1; run_cycle(); nxt_rst = 1'b0;
    spur_pct = 100; run_n(4); spur_pct = 0;
    check("rst_no_rsp", DW'(rsp_cnt - r0), 0);
    dly_min = 0;

    // contention: both requesters valid all the time
    do_reset();
    dly_max = 2; contend = 1;
    g0 = grant_log.size(); r0 = rsp_cnt;
    run_n(60);
    contend = 0; nxt_valid = 2'b00;
    wait_idle();
    for (int k = g0; k < grant_log.size(); k++) check("grant_alternate", DW'(grant_log[k]), DW'((k - g0) % 2));
    check("contend_no_lost", DW'(rsp_cnt - r0), DW'(grant_log.size() - g0));

`ifdef SPARCE_MEM_ARB_TIMEOUT_EN
    // watchdog: memory never accepts
    ready_pct = 0;
    set_req(0, 1'b0, WORD_OP, 32'h0000_0040, '0);
    wait_idle();
    check("tmo_rsp_err", DW'(last_err), 1);
    check("tmo_rsp_rdata", last_rdata, 0);
    check("tmo_latency", DW'(last_lat), DW'(TMO + 1));
    ready_pct = 100;
`endif

    // randomized traffic with stray completions and occasional resets
    auto_req = 1; ready_pct = 60; dly_max = 3; spur_pct = 10; rst_pm = 3;
    run_n(3000);
    auto_req = 0; rst_pm = 0; spur_pct = 0;
    wait_idle();
    check("final_queue_empty", DW'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
